hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller; drives stall/flush of IF_ID and ID_EX, operand-forward selects for EX.
//  Keeps a shadow pipeline (EX/MEM/WB) of rd, rs1, rs2, write-enable and load flags.
//  Detects load-use and RAW hazards and taken branches/jumps resolved in EX.
//  Keeps stall/flush event counters for performance debug.
// PARAMETERS
//  FORWARD          1  1: EX forwarding exists, only load-use stalls; 0: stall until producer retires
//  RF_WRITE_THROUGH 1  1: regfile reads see same-cycle WB write; 0: WB match also stalls (FORWARD=0 only)
// PORTS
//  clk_i        in   1   clock, all state on posedge
//  rst_ni       in   1   reset, synchronous, active-low
//  instr_ID     in   32  instruction currently in ID
//  RegWEn_ID    in   1   ID instr writes rd
//  WBSel_ID     in   2   ID writeback select; 2'b00 = DMEM (load)
//  PCSel_EX     in   1   EX redirects PC (taken branch / jump)
//  stall_IF     out  1   hold PC
//  stall_ID     out  1   hold IF_ID
//  flush_IF     out  1   zero IF_ID on next edge
//  flush_ID     out  1   zero ID_EX on next edge (bubble)
//  fwdA_sel     out  2   EX rs1 source: 00 regfile, 01 MEM ALU result, 10 WB data
//  fwdB_sel     out  2   EX rs2 source, same encoding
//  stall_cnt_o  out  32  cycles with stall_ID=1
//  flush_cnt_o  out  32  cycles with PCSel_EX=1
// BEHAVIOUR
//  Decode: rs1=[19:15], rs2=[24:20], rd=[11:7], op=[6:0].
//   rs1 used unless op in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}; rs2 used only for op in {0110011, 0100011, 1100011}.
//   rd==0 or RegWEn=0 never produces a hazard or forward.
//  Shadow pipeline, every posedge:
//   EX <= flush_ID ? invalid : ID entry; MEM <= EX; WB <= MEM.
//   Stall holds ID instr in place while EX takes a bubble.
//  Hazard (combinational from shadow + ID):
//   FORWARD=1: haz = EX.load & EX.wen & rd match on a used rs.
//   FORWARD=0: haz = match vs EX or MEM, plus WB when RF_WRITE_THROUGH=0.
//  Outputs, all combinational:
//   PCSel_EX=1 -> flush_IF=1, flush_ID=1, stall_IF=stall_ID=0. Branch overrides hazard.
//   else haz -> stall_IF=1, stall_ID=1, flush_ID=1, flush_IF=0.
//   else all 0.
//  Forwarding (FORWARD=1, for the instr in EX):
//   MEM match -> 01; else WB match -> 10; else 00. MEM has priority over WB.
//   FORWARD=0 -> always 00.
//  Counters wrap at 2^32; each increments at most once per cycle.
//  Reset (rst_ni=0 at posedge):
//   all shadow entries invalid, counters 0; hence all outputs 0 the cycle after.
//   Reset mid-stall drops the pending stall; no residual stall or flush afterwards.
// TESTING
//  T1 rst_ni=0 two cycles, then release with NOP in ID -> stall_*/flush_* 0, fwd*=00, counters 0.
//  T2 FORWARD=1: lw x5,0(x1) then add x6,x5,x2 ->
//     one cycle of stall_IF=stall_ID=flush_ID=1, stall_cnt=1; when add reaches EX, fwdA_sel=10.
//  T3 FORWARD=1: add x5,x1,x2 then sub x7,x5,x5 -> no stall; sub in EX gives fwdA_sel=fwdB_sel=01.
//  T4 load-use hazard and PCSel_EX=1 in same cycle ->
//     flush_IF=flush_ID=1, stall=0; flush_cnt +1, stall_cnt unchanged.
//  T5 lw x0,0(x1) then add x6,x0,x0 -> no stall, fwd 00.
//     FORWARD=0: add x5 then use x5 -> 2 stall cycles (RF_WRITE_THROUGH=1), 3 (RF_WRITE_THROUGH=0).
//  T6 assert rst_ni=0 during a FORWARD=0 stall ->
//     next cycle all outputs 0, counters 0, no further stall.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard-controller bundle: ID/EX decode inputs in, pipeline steering and perf counters out.
// The master side is the pipeline datapath; the slave side is hazard_unit.
interface hazard_unit_if;
    logic [31:0] instr_ID;
    logic        RegWEn_ID;
    logic [1:0]  WBSel_ID;
    logic        PCSel_EX;
    logic        stall_IF;
    logic        stall_ID;
    logic        flush_IF;
    logic        flush_ID;
    logic [1:0]  fwdA_sel;
    logic [1:0]  fwdB_sel;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    modport master (
        output instr_ID, RegWEn_ID, WBSel_ID, PCSel_EX,
        input  stall_IF, stall_ID, flush_IF, flush_ID,
        input  fwdA_sel, fwdB_sel, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  instr_ID, RegWEn_ID, WBSel_ID, PCSel_EX,
        output stall_IF, stall_ID, flush_IF, flush_ID,
        output fwdA_sel, fwdB_sel, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: tracks rd/rs of EX/MEM/WB in a shadow pipeline and
// produces stall, flush and EX forward selects plus stall/flush event counters.
module hazard_unit #(
    parameter bit FORWARD          = 1'b1,
    parameter bit RF_WRITE_THROUGH = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    hazard_unit_if.slave hz
);

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    endfunction

    // ID decode
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_use, id_rs2_use, id_wen, id_load;
    logic       unused_instr_bits;

    assign id_rs1     = hz.instr_ID[19:15];
    assign id_rs2     = hz.instr_ID[24:20];
    assign id_rd      = hz.instr_ID[11:7];
    assign id_rs1_use = uses_rs1(hz.instr_ID[6:0]);
    assign id_rs2_use = uses_rs2(hz.instr_ID[6:0]);
    // Writes to x0 are folded away here so nothing downstream can match on them.
    assign id_wen     = hz.RegWEn_ID && (id_rd != 5'd0);
    assign id_load    = (hz.WBSel_ID == 2'b00);
    assign unused_instr_bits = ^{hz.instr_ID[31:25], hz.instr_ID[14:12]};

    // Shadow pipeline state
    logic       ex_vld_q;
    logic       ex_wen_q, ex_load_q, ex_rs1_use_q, ex_rs2_use_q;
    logic [4:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic       mem_wen_q, wb_wen_q;
    logic [4:0] mem_rd_q, wb_rd_q;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    function automatic logic id_reads(input logic [4:0] rd);
        return (id_rs1_use && id_rs1 == rd) || (id_rs2_use && id_rs2 == rd);
    endfunction

    logic ex_hit, mem_hit, wb_hit, haz;

    assign ex_hit  = ex_vld_q && ex_wen_q && id_reads(ex_rd_q);
    assign mem_hit = mem_wen_q && id_reads(mem_rd_q);
    assign wb_hit  = wb_wen_q && id_reads(wb_rd_q);
    assign haz     = FORWARD ? (ex_hit && ex_load_q)
                             : (ex_hit || mem_hit || (!RF_WRITE_THROUGH && wb_hit));

    function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs);
        if (!FORWARD || !ex_vld_q || !use_rs) return 2'b00;
        if (mem_wen_q && mem_rd_q == rs)      return 2'b01;
        if (wb_wen_q && wb_rd_q == rs)        return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        hz.stall_IF = 1'b0;
        hz.stall_ID = 1'b0;
        hz.flush_IF = 1'b0;
        hz.flush_ID = 1'b0;
        // A redirect kills the hazarding instruction anyway, so it wins over a stall.
        if (hz.PCSel_EX) begin
            hz.flush_IF = 1'b1;
            hz.flush_ID = 1'b1;
        end else if (haz) begin
            hz.stall_IF = 1'b1;
            hz.stall_ID = 1'b1;
            hz.flush_ID = 1'b1;
        end
    end

    assign hz.fwdA_sel    = fwd_sel(ex_rs1_use_q, ex_rs1_q);
    assign hz.fwdB_sel    = fwd_sel(ex_rs2_use_q, ex_rs2_q);
    assign stall_cnt_d    = stall_cnt_q + {31'd0, hz.stall_ID};
    assign flush_cnt_d    = flush_cnt_q + {31'd0, hz.PCSel_EX};
    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;

    // ID -> EX -> MEM -> WB, control (validity, counters)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_vld_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            wb_wen_q    <= 1'b0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            ex_vld_q    <= !hz.flush_ID;
            mem_wen_q   <= ex_vld_q && ex_wen_q;
            wb_wen_q    <= mem_wen_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ID -> EX -> MEM -> WB, register indices and flags (qualified by validity above)
    always_ff @(posedge clk_i) begin
        ex_wen_q     <= id_wen;
        ex_load_q    <= id_load;
        ex_rd_q      <= id_rd;
        ex_rs1_q     <= id_rs1;
        ex_rs2_q     <= id_rs2;
        ex_rs1_use_q <= id_rs1_use;
        ex_rs2_use_q <= id_rs2_use;
        mem_rd_q     <= ex_rd_q;
        wb_rd_q      <= mem_rd_q;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one instance per FORWARD/RF_WRITE_THROUGH variant,
// all fed the same ID/EX stimulus.
module tb_hazard_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] LW5  = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] LW0  = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD6 = 32'h0022_8333; // add  x6,x5,x2
    localparam logic [31:0] ADD5 = 32'h0020_82B3; // add  x5,x1,x2
    localparam logic [31:0] SUB7 = 32'h4052_83B3; // sub  x7,x5,x5
    localparam logic [31:0] ADD0 = 32'h0000_0333; // add  x6,x0,x0

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        regwen;
    logic [1:0]  wbsel;
    logic        pcsel;
    int          checks;
    int          failures;

    hazard_unit_if if_f1 ();
    hazard_unit_if if_wt1 ();
    hazard_unit_if if_wt0 ();

    assign if_f1.instr_ID   = instr;
    assign if_f1.RegWEn_ID  = regwen;
    assign if_f1.WBSel_ID   = wbsel;
    assign if_f1.PCSel_EX   = pcsel;
    assign if_wt1.instr_ID  = instr;
    assign if_wt1.RegWEn_ID = regwen;
    assign if_wt1.WBSel_ID  = wbsel;
    assign if_wt1.PCSel_EX  = pcsel;
    assign if_wt0.instr_ID  = instr;
    assign if_wt0.RegWEn_ID = regwen;
    assign if_wt0.WBSel_ID  = wbsel;
    assign if_wt0.PCSel_EX  = pcsel;

    hazard_unit #(.FORWARD(1'b1), .RF_WRITE_THROUGH(1'b1)) u_f1 (
        .clk_i (clk), .rst_ni(rst_n), .hz(if_f1.slave));
    hazard_unit #(.FORWARD(1'b0), .RF_WRITE_THROUGH(1'b1)) u_wt1 (
        .clk_i (clk), .rst_ni(rst_n), .hz(if_wt1.slave));
    hazard_unit #(.FORWARD(1'b0), .RF_WRITE_THROUGH(1'b0)) u_wt0 (
        .clk_i (clk), .rst_ni(rst_n), .hz(if_wt0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [1:0] s, input logic p);
        instr  = i;
        regwen = 1'b1;
        wbsel  = s;
        pcsel  = p;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {stall_IF, stall_ID, flush_IF, flush_ID}
    logic [3:0] fl_f1, fl_wt1, fl_wt0;
    assign fl_f1  = {if_f1.stall_IF,  if_f1.stall_ID,  if_f1.flush_IF,  if_f1.flush_ID};
    assign fl_wt1 = {if_wt1.stall_IF, if_wt1.stall_ID, if_wt1.flush_IF, if_wt1.flush_ID};
    assign fl_wt0 = {if_wt0.stall_IF, if_wt0.stall_ID, if_wt0.flush_IF, if_wt0.flush_ID};

    initial begin
        checks   = 0;
        failures = 0;

        // T1: reset
        rst_n = 1'b0;
        drive(NOP, 2'b01, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(NOP, 2'b01, 1'b0);
        check("t1_flags_f1", {28'd0, fl_f1}, 32'h0);
        check("t1_fwd_f1", {28'd0, if_f1.fwdA_sel, if_f1.fwdB_sel}, 32'h0);
        check("t1_scnt_f1", if_f1.stall_cnt_o, 32'd0);
        check("t1_fcnt_f1", if_f1.flush_cnt_o, 32'd0);
        check("t1_flags_wt0", {28'd0, fl_wt0}, 32'h0);
        check("t1_scnt_wt0", if_wt0.stall_cnt_o, 32'd0);
        tick();

        // T2: load-use, one stall then WB forward
        drive(LW5, 2'b00, 1'b0);
        check("t2_lw_flags", {28'd0, fl_f1}, 32'h0);
        tick();
        drive(ADD6, 2'b01, 1'b0);
        check("t2_stall_flags", {28'd0, fl_f1}, 32'hD);
        check("t2_scnt0", if_f1.stall_cnt_o, 32'd0);
        tick();
        drive(ADD6, 2'b01, 1'b0);
        check("t2_release_flags", {28'd0, fl_f1}, 32'h0);
        check("t2_scnt1", if_f1.stall_cnt_o, 32'd1);
        tick();
        drive(NOP, 2'b01, 1'b0);
        check("t2_fwdA", {30'd0, if_f1.fwdA_sel}, 32'd2);
        check("t2_fwdB", {30'd0, if_f1.fwdB_sel}, 32'd0);
        tick();

        // T3: ALU RAW, MEM beats WB
        drive(ADD5, 2'b01, 1'b0);
        check("t3_flags_a", {28'd0, fl_f1}, 32'h0);
        tick();
        drive(ADD5, 2'b01, 1'b0);
        check("t3_flags_b", {28'd0, fl_f1}, 32'h0);
        tick();
        drive(SUB7, 2'b01, 1'b0);
        check("t3_flags_c", {28'd0, fl_f1}, 32'h0);
        tick();
        drive(NOP, 2'b01, 1'b0);
        check("t3_fwdA", {30'd0, if_f1.fwdA_sel}, 32'd1);
        check("t3_fwdB", {30'd0, if_f1.fwdB_sel}, 32'd1);
        tick();

        // T4: branch overrides load-use
        drive(LW5, 2'b00, 1'b0);
        tick();
        drive(ADD6, 2'b01, 1'b1);
        check("t4_flags", {28'd0, fl_f1}, 32'h3);
        tick();
        drive(NOP, 2'b01, 1'b0);
        check("t4_fcnt", if_f1.flush_cnt_o, 32'd1);
        check("t4_scnt", if_f1.stall_cnt_o, 32'd1);
        check("t4_flags_after", {28'd0, fl_f1}, 32'h0);
        tick();

        // T5a: x0 never hazards or forwards
        drive(LW0, 2'b00, 1'b0);
        tick();
        drive(ADD0, 2'b01, 1'b0);
        check("t5_x0_flags", {28'd0, fl_f1}, 32'h0);
        tick();
        drive(NOP, 2'b01, 1'b0);
        check("t5_x0_fwd", {28'd0, if_f1.fwdA_sel, if_f1.fwdB_sel}, 32'h0);
        tick();

        // T5b: FORWARD=0 stall lengths
        rst_n = 1'b0;
        drive(NOP, 2'b01, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(ADD5, 2'b01, 1'b0);
        check("t5_prod_wt1", {28'd0, fl_wt1}, 32'h0);
        tick();
        drive(ADD6, 2'b01, 1'b0);
        check("t5_c1_wt1", {28'd0, fl_wt1}, 32'hD);
        check("t5_c1_wt0", {28'd0, fl_wt0}, 32'hD);
        check("t5_c1_f1", {28'd0, fl_f1}, 32'h0);
        tick();
        drive(ADD6, 2'b01, 1'b0);
        check("t5_c2_wt1", {28'd0, fl_wt1}, 32'hD);
        check("t5_c2_wt0", {28'd0, fl_wt0}, 32'hD);
        tick();
        drive(ADD6, 2'b01, 1'b0);
        check("t5_c3_wt1", {28'd0, fl_wt1}, 32'h0);
        check("t5_c3_wt0", {28'd0, fl_wt0}, 32'hD);
        tick();
        drive(NOP, 2'b01, 1'b0);
        check("t5_c4_wt0", {28'd0, fl_wt0}, 32'h0);
        check("t5_scnt_wt1", if_wt1.stall_cnt_o, 32'd2);
        check("t5_scnt_wt0", if_wt0.stall_cnt_o, 32'd3);
        check("t5_fwd_wt1", {28'd0, if_wt1.fwdA_sel, if_wt1.fwdB_sel}, 32'h0);
        tick();

        // T6: reset in the middle of a FORWARD=0 stall
        drive(ADD5, 2'b01, 1'b0);
        tick();
        drive(ADD6, 2'b01, 1'b0);
        check("t6_pre_wt0", {28'd0, fl_wt0}, 32'hD);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(ADD6, 2'b01, 1'b0);
        check("t6_flags_wt0", {28'd0, fl_wt0}, 32'h0);
        check("t6_flags_wt1", {28'd0, fl_wt1}, 32'h0);
        check("t6_scnt_wt0", if_wt0.stall_cnt_o, 32'd0);
        check("t6_fcnt_wt0", if_wt0.flush_cnt_o, 32'd0);
        tick();
        drive(ADD6, 2'b01, 1'b0);
        check("t6_next_wt0", {28'd0, fl_wt0}, 32'h0);
        check("t6_next_scnt", if_wt0.stall_cnt_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
